// File: rtl/iob_fifo_ctrl.sv
// iob_fifo_ctrl: FIFO controller for an external two-port RAM with 1-cycle
// registered read data.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   w_en, w_data      user write request / word
//   w_full            FIFO holds 2^ADDR_W words
//   r_en, r_data      user read request / word (r_data comes straight from RAM)
//   r_empty           FIFO holds 0 words
//   level             current word count (0..2^ADDR_W)
//   w_overflow        sticky write-when-full flag
//   r_underflow       sticky read-when-empty flag
//   ext_mem_*         RAM write/read port, enables and addresses combinational
//
// Optional feature: define IOB_FIFO_CTRL_ERR_EN to build the sticky
// overflow/underflow flag registers; otherwise both flags are tied to 0.
module iob_fifo_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_en,
  input  logic [DATA_W-1:0] w_data,
  output logic              w_full,
  input  logic              r_en,
  output logic [DATA_W-1:0] r_data,
  output logic              r_empty,
  output logic [ADDR_W:0]   level,
  output logic              w_overflow,
  output logic              r_underflow,
  output logic              ext_mem_w_en,
  output logic [ADDR_W-1:0] ext_mem_w_addr,
  output logic [DATA_W-1:0] ext_mem_w_data,
  output logic              ext_mem_r_en,
  output logic [ADDR_W-1:0] ext_mem_r_addr,
  input  logic [DATA_W-1:0] ext_mem_r_data
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned LVL_W = ADDR_W + 1;

  logic [ADDR_W-1:0] w_ptr;
  logic [ADDR_W-1:0] r_ptr;
  logic [LVL_W-1:0]  level_q;
  logic              w_acc;
  logic              r_acc;

  // Status flags derive from the registered level only.
  assign level   = level_q;
  assign w_full  = (level_q == LVL_W'(DEPTH));
  assign r_empty = (level_q == '0);

  // Accept qualifiers; reset masks RAM enables regardless of requests.
  assign w_acc = w_en & ~w_full & ~rst;
  assign r_acc = r_en & ~r_empty & ~rst;

  assign ext_mem_w_en   = w_acc;
  assign ext_mem_w_addr = w_ptr;
  assign ext_mem_w_data = w_data;
  assign ext_mem_r_en   = r_acc;
  assign ext_mem_r_addr = r_ptr;

  // RAM read register already holds the word until the next accepted read.
  assign r_data = ext_mem_r_data;

  // Pointers wrap naturally at ADDR_W bits; level tracks net occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_ptr   <= '0;
      r_ptr   <= '0;
      level_q <= '0;
    end else begin
      if (w_acc) w_ptr <= w_ptr + ADDR_W'(1);
      if (r_acc) r_ptr <= r_ptr + ADDR_W'(1);
      case ({w_acc, r_acc})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

`ifdef IOB_FIFO_CTRL_ERR_EN
  logic ovf_q;
  logic udf_q;

  // Sticky error flags: set by any rejected request, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (w_en && w_full)  ovf_q <= 1'b1;
      if (r_en && r_empty) udf_q <= 1'b1;
    end
  end

  assign w_overflow  = ovf_q;
  assign r_underflow = udf_q;
`else
  assign w_overflow  = 1'b0;
  assign r_underflow = 1'b0;
`endif

endmodule

// File: doc/iob_fifo_ctrl.md
IOB_FIFO_CTRL -- requirements
Module: iob_fifo_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 4, RAM address width; FIFO depth = 2^ADDR_W words.
REQ-003 SHALL have one clock and a synchronous active-high reset: clk is the only clock and rst is synchronous, active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 w_en  input  1  user write request.
REQ-007 w_data  input  DATA_W  user write word.
REQ-008 w_full  output  1  FIFO holds 2^ADDR_W words.
REQ-009 r_en  input  1  user read request.
REQ-010 r_data  output  DATA_W  read word; direct from ext_mem_r_data.
REQ-011 r_empty  output  1  FIFO holds 0 words.
REQ-012 level  output  ADDR_W+1  current word count.
REQ-013 w_overflow  output  1  sticky write-when-full flag (see Configuration).
REQ-014 r_underflow  output  1  sticky read-when-empty flag (see Configuration).
REQ-015 ext_mem_w_en  output  1  RAM write enable.
REQ-016 ext_mem_w_addr  output  ADDR_W  RAM write address.
REQ-017 ext_mem_w_data  output  DATA_W  RAM write data.
REQ-018 ext_mem_r_en  output  1  RAM read enable.
REQ-019 ext_mem_r_addr  output  ADDR_W  RAM read address.
REQ-020 ext_mem_r_data  input  DATA_W  RAM registered read data, 1-cycle latency.

Function
REQ-021 Write accepted iff w_en=1 and w_full=0; then ext_mem_w_en=1, ext_mem_w_addr=write pointer, ext_mem_w_data=w_data, same cycle (combinational).
REQ-022 Read accepted iff r_en=1 and r_empty=0; then ext_mem_r_en=1, ext_mem_r_addr=read pointer, same cycle.
REQ-023 r_data SHALL be valid the cycle after the accepting read edge and SHALL hold until the next accepted read.
REQ-024 Write/read pointers increment by 1 per accepted operation, wrapping modulo 2^ADDR_W (2^ADDR_W-1 -> 0).
REQ-025 level +1 on write-only, -1 on read-only, unchanged on both or neither; range 0..2^ADDR_W.
REQ-026 w_full = (level == 2^ADDR_W); r_empty = (level == 0); both derived from registered level.
REQ-027 Write when full SHALL be rejected even with a simultaneous accepted read; no RAM write, no pointer change.
REQ-028 Read when empty SHALL be rejected even with a simultaneous accepted write; no RAM read.
REQ-029 Rejected requests SHALL NOT drive ext_mem_w_en/ext_mem_r_en.

Reset
REQ-030 On rst=1 at a clk edge: pointers=0, level=0, r_empty=1, w_full=0, w_overflow=0, r_underflow=0.
REQ-031 During rst=1, ext_mem_w_en=0 and ext_mem_r_en=0 regardless of w_en/r_en.
REQ-032 Reset mid-operation SHALL discard all buffered words; RAM contents are not cleared.

Configuration
REQ-033 Macro IOB_FIFO_CTRL_ERR_EN controls error flags.
REQ-034 Defined: w_overflow set on any rejected write (REQ-027), r_underflow set on any rejected read (REQ-028), one cycle after the request edge; both sticky until rst.
REQ-035 Undefined: w_overflow and r_underflow present but tied to 0; no flag registers.

Verification (DATA_W=8, ADDR_W=4, paired with the team's two-port RAM with both clocks tied to clk)
REQ-036 Reset then idle -> level=0, r_empty=1, w_full=0, ext_mem_w_en=ext_mem_r_en=0.
REQ-037 Write 16 words i+32 (i=0..15) -> level=16, w_full=1 after 16th edge; ext_mem_w_addr=0..15 in order.
REQ-038 From full, 17th write (data 99) -> no ext_mem_w_en, level stays 16; w_overflow=1 only with IOB_FIFO_CTRL_ERR_EN.
REQ-039 Read 16 words -> r_data=32..47 each one cycle after read edge; r_empty=1 after last; extra read gives r_underflow=1 (ERR_EN) and r_data holds 47.
REQ-040 Level 5, simultaneous w_en=r_en=1 for 20 cycles -> level stays 5, pointers wrap past 15, data order preserved.
REQ-041 Level 8, assert rst one cycle -> level=0, r_empty=1, flags 0; next write goes to ext_mem_w_addr=0.
